// File: rtl/reg_sched_pkg.sv
// Shared constants and types for the register writeback scheduler.
// Covers the tracked register range, the in-flight limit, the requester indices and the writeback request record.
package reg_sched_pkg;
  localparam int NUM_TRACKED  = 29;
  localparam int MAX_INFLIGHT = 5;
  localparam int REG_W        = 5;
  localparam int DATA_W       = 32;
  localparam int CNT_W        = 3;

  localparam logic [REG_W-1:0] REG_LO = 5'd30;
  localparam logic [REG_W-1:0] REG_HI = 5'd31;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a combinational one-hot grant.
// After any grant, the pointer moves to the requester that was not served.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  import reg_sched_pkg::*;

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = '0;
      grant[ptr ? REQ_MEM : REQ_ALU] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant[REQ_ALU]) begin
      ptr <= 1'b1;
    end else if (grant[REQ_MEM]) begin
      ptr <= 1'b0;
    end
  end
endmodule

// File: rtl/reg_wb_scheduler.sv
// Scoreboard of in-flight writes for r1..NUM_TRACKED, plus writeback arbitration between ALU and MEM.
// The granted writeback is forwarded to the register file one cycle later.
module reg_wb_scheduler #(
  parameter int NUM_TRACKED  = reg_sched_pkg::NUM_TRACKED,
  parameter int MAX_INFLIGHT = reg_sched_pkg::MAX_INFLIGHT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs,
  input  logic [4:0]      issue_rt,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [1:0]      wb_valid,
  input  logic [1:0][4:0] wb_rd,
  input  logic [1:0][31:0] wb_data,
  output logic [1:0]      wb_grant,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            busy_any,
  output logic            err_underflow
);
  import reg_sched_pkg::*;

  logic [CNT_W-1:0] cnt      [1:NUM_TRACKED];
  logic [CNT_W-1:0] cnt_view [0:31];
  wb_req_t          req_sel_p0;
  logic             gnt_any_p0;
  logic             fire_p0;
  logic             inc_trk;
  logic             dec_trk;
  logic             dec_ok;

  function automatic logic is_tracked(input logic [4:0] r);
    return (r != 5'd0) && (int'(r) <= NUM_TRACKED);
  endfunction

  // Untracked registers (r0, lo, hi) read as a permanently zero counter.
  always_comb begin
    for (int i = 0; i < 32; i++) cnt_view[i] = '0;
    for (int i = 1; i <= NUM_TRACKED; i++) cnt_view[i] = cnt[i];
  end

  always_comb begin
    issue_ready = (cnt_view[issue_rs] == '0) && (cnt_view[issue_rt] == '0);
    if (is_tracked(issue_rd) && (int'(cnt_view[issue_rd]) >= MAX_INFLIGHT))
      issue_ready = 1'b0;
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wb_valid),
    .grant (wb_grant)
  );

  always_comb begin
    req_sel_p0.rd   = wb_rd[REQ_ALU];
    req_sel_p0.data = wb_data[REQ_ALU];
    if (wb_grant[REQ_MEM]) begin
      req_sel_p0.rd   = wb_rd[REQ_MEM];
      req_sel_p0.data = wb_data[REQ_MEM];
    end
  end

  assign gnt_any_p0 = |wb_grant;
  assign fire_p0    = issue_valid & issue_ready;
  assign inc_trk    = fire_p0 & is_tracked(issue_rd);
  assign dec_trk    = gnt_any_p0 & is_tracked(req_sel_p0.rd);
  assign dec_ok     = dec_trk & (cnt_view[req_sel_p0.rd] != '0);

  // p0 -> p1: register-file write stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= gnt_any_p0;
      if (gnt_any_p0) begin
        rf_waddr <= req_sel_p0.rd;
        rf_wdata <= req_sel_p0.data;
      end
    end
  end

  // An issue and a writeback hitting the same register in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= NUM_TRACKED; i++) cnt[i] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 1; i <= NUM_TRACKED; i++) begin
        if (inc_trk && (issue_rd == 5'(i)) && !(dec_trk && (req_sel_p0.rd == 5'(i))))
          cnt[i] <= cnt[i] + 3'd1;
        else if (dec_ok && (req_sel_p0.rd == 5'(i)) && !(inc_trk && (issue_rd == 5'(i))))
          cnt[i] <= cnt[i] - 3'd1;
      end
      if (dec_trk && !dec_ok) err_underflow <= 1'b1;
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int i = 1; i <= NUM_TRACKED; i++) busy_any = busy_any | (cnt[i] != '0);
  end
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Testbench for reg_wb_scheduler: directed scenarios followed by randomized traffic.
// The random traffic is compared against a per-register count model.
module tb_reg_wb_scheduler;
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             issue_valid = 1'b0;
  logic [4:0]       issue_rs = '0, issue_rt = '0, issue_rd = '0;
  logic             issue_ready;
  logic [1:0]       wb_valid = '0;
  logic [1:0][4:0]  wb_rd = '0;
  logic [1:0][31:0] wb_data = '0;
  logic [1:0]       wb_grant;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             busy_any;
  logic             err_underflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_wb_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_rd      (issue_rd),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_grant      (wb_grant),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .busy_any      (busy_any),
    .err_underflow (err_underflow)
  );

  task automatic set_in(input logic iv, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [1:0] wv, input logic [4:0] ra, input logic [31:0] da,
                        input logic [4:0] rm, input logic [31:0] dm);
    @(negedge clk);
    issue_valid = iv; issue_rs = rs; issue_rt = rt; issue_rd = rd;
    wb_valid = wv; wb_rd[0] = ra; wb_data[0] = da; wb_rd[1] = rm; wb_data[1] = dm;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    issue_valid = 1'b0; wb_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", issue_ready); end
    checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy_any); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b want=0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d want=0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h want=0", rf_wdata); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", err_underflow); end
    checks++; if (wb_grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b want=00", wb_grant); end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_raw_hazard();
    do_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_first_ready got=%0b want=1", issue_ready); end
    tick();
    checks++; if (busy_any !== 1'b1) begin failures++; $display("FAIL raw_busy got=%0b want=1", busy_any); end
    set_in(1'b1, 5'd5, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%0b want=0", issue_ready); end
    set_in(1'b0, 5'd5, 5'd0, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
    checks++; if (wb_grant !== 2'b01) begin failures++; $display("FAIL raw_grant got=%b want=01", wb_grant); end
    tick();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL raw_we got=%0b want=1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL raw_waddr got=%0d want=5", rf_waddr); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_wdata got=%h want=deadbeef", rf_wdata); end
    checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL raw_busy_after got=%0b want=0", busy_any); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_ready_after got=%0b want=1", issue_ready); end
    idle();
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL raw_we_drop got=%0b want=0", rf_we); end
  endtask

  task automatic test_max_inflight();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 5'd0, 5'd0, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
      checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL max_ready_%0d got=%0b want=1", k, issue_ready); end
      tick();
    end
    set_in(1'b1, 5'd0, 5'd0, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL max_sixth got=%0b want=0", issue_ready); end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd7, 32'h7777, 5'd0, 32'd0);
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL max_after_wb got=%0b want=1", issue_ready); end
    idle();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [4:0] exp_a;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd30, 32'hA0000000 + k, 5'd31, 32'hB0000000 + k);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 5'd30 : 5'd31;
      checks++; if (wb_grant !== exp_g) begin failures++; $display("FAIL rr_grant_%0d got=%b want=%b", k, wb_grant, exp_g); end
      tick();
      checks++; if (rf_waddr !== exp_a || rf_we !== 1'b1) begin failures++; $display("FAIL rr_waddr_%0d got=%0d/%0b want=%0d/1", k, rf_waddr, rf_we, exp_a); end
    end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL rr_err got=%0b want=0", err_underflow); end
    idle();
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd3, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd3, 2'b01, 5'd3, 32'h33, 5'd0, 32'd0);
    checks++; if (issue_ready !== 1'b1 || wb_grant !== 2'b01) begin failures++; $display("FAIL same_fire got=%0b/%b want=1/01", issue_ready, wb_grant); end
    tick();
    checks++; if (busy_any !== 1'b1) begin failures++; $display("FAIL same_busy got=%0b want=1", busy_any); end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd3, 32'h34, 5'd0, 32'd0);
    tick();
    checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL same_drain got=%0b want=0", busy_any); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL same_err got=%0b want=0", err_underflow); end
    idle();
  endtask

  task automatic test_underflow();
    do_reset();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 5'd9, 32'h99, 5'd0, 32'd0);
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin failures++; $display("FAIL uf_write got=%0b/%0d want=1/9", rf_we, rf_waddr); end
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_set got=%0b want=1", err_underflow); end
    idle();
    tick(); tick();
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%0b want=1", err_underflow); end
    do_reset();
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_cleared got=%0b want=0", err_underflow); end
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 2'b10, 5'd0, 32'd0, 5'd31, 32'h31);
    checks++; if (wb_grant !== 2'b10) begin failures++; $display("FAIL uf_hi_grant got=%b want=10", wb_grant); end
    tick();
    checks++; if (rf_waddr !== 5'd31 || rf_wdata !== 32'h31) begin failures++; $display("FAIL uf_hi_write got=%0d/%h want=31/31", rf_waddr, rf_wdata); end
    checks++; if (err_underflow !== 1'b0) begin failures++; $display("FAIL uf_hi_err got=%0b want=0", err_underflow); end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(1'b1, 5'd0, 5'd0, 5'd4, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd6, 2'b01, 5'd30, 32'h1234, 5'd0, 32'd0);
    tick();
    checks++; if (rf_we !== 1'b1 || busy_any !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0b/%0b want=1/1", rf_we, busy_any); end
    set_in(1'b0, 5'd4, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL ar_stall got=%0b want=0", issue_ready); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL ar_we got=%0b want=0", rf_we); end
    checks++; if (busy_any !== 1'b0) begin failures++; $display("FAIL ar_busy got=%0b want=0", busy_any); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%0b want=1", issue_ready); end
    checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL ar_waddr got=%0d want=0", rf_waddr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 6);
    return (r < 5) ? 5'(r) : ((r == 5) ? 5'd30 : 5'd31);
  endfunction

  function automatic bit trk(input logic [4:0] r);
    return (r >= 5'd1) && (r <= 5'd29);
  endfunction

  task automatic test_random();
    int         mc [32];
    int         ptr_m;
    bit         err_m, pa, pm, iv, exp_ready, fire, ev, any_busy;
    logic [4:0] rs, rt, rd, ra, rm, grd, ea;
    logic [31:0] da, dm, ed;
    logic [1:0] eg;
    do_reset();
    for (int i = 0; i < 32; i++) mc[i] = 0;
    ptr_m = 0; err_m = 0; pa = 0; pm = 0;
    ra = '0; rm = '0; da = '0; dm = '0;
    for (int c = 0; c < 600; c++) begin
      iv = ($urandom_range(0, 3) != 0);
      rs = pick_reg(); rt = pick_reg(); rd = pick_reg();
      if (!pa && $urandom_range(0, 1) == 1) begin pa = 1; ra = pick_reg(); da = $urandom; end
      if (!pm && $urandom_range(0, 1) == 1) begin pm = 1; rm = pick_reg(); dm = $urandom; end
      set_in(iv, rs, rt, rd, {pm, pa}, ra, da, rm, dm);
      exp_ready = (mc[rs] == 0) && (mc[rt] == 0) && (!trk(rd) || mc[rd] < 5);
      if (pa && pm) eg = (ptr_m == 0) ? 2'b01 : 2'b10;
      else eg = {pm, pa};
      checks++; if (issue_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, issue_ready, exp_ready); end
      checks++; if (wb_grant !== eg) begin failures++; $display("FAIL rnd_grant c=%0d got=%b want=%b", c, wb_grant, eg); end
      fire = iv && exp_ready;
      ev = (eg != 2'b00);
      grd = eg[0] ? ra : rm;
      ea = grd; ed = eg[0] ? da : dm;
      if (eg[0]) begin pa = 0; ptr_m = 1; end
      if (eg[1]) begin pm = 0; ptr_m = 0; end
      if (ev && trk(grd) && mc[grd] == 0) err_m = 1;
      if (fire && trk(rd) && ev && trk(grd) && rd == grd) begin
        // issue and writeback to one register leave its count alone
      end else begin
        if (fire && trk(rd)) mc[rd]++;
        if (ev && trk(grd) && mc[grd] > 0) mc[grd]--;
      end
      tick();
      any_busy = 0;
      for (int i = 1; i <= 29; i++) if (mc[i] != 0) any_busy = 1;
      checks++; if (rf_we !== ev) begin failures++; $display("FAIL rnd_we c=%0d got=%0b want=%0b", c, rf_we, ev); end
      if (ev) begin
        checks++; if (rf_waddr !== ea || rf_wdata !== ed) begin failures++; $display("FAIL rnd_write c=%0d got=%0d/%h want=%0d/%h", c, rf_waddr, rf_wdata, ea, ed); end
      end
      checks++; if (busy_any !== any_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%0b want=%0b", c, busy_any, any_busy); end
      checks++; if (err_underflow !== err_m) begin failures++; $display("FAIL rnd_err c=%0d got=%0b want=%0b", c, err_underflow, err_m); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_max_inflight();
    test_round_robin();
    test_same_cycle();
    test_underflow();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
